// File: rtl/round_timer_controller_pkg.sv
// Shared game package: FSM state encoding, default game constants and the
// round-length helper used by the round timer controller and its bench.
package round_timer_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ARM     = 3'd2,
        S_RUN     = 3'd3,
        S_ADVANCE = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    localparam int DEFAULT_INIT_TIME = 9;
    localparam int DEFAULT_MIN_TIME  = 3;
    localparam int DEFAULT_MAX_LEVEL = 9;
    localparam int DEFAULT_LIVES     = 3;

    // Round length for a level: max(init - level, min), evaluated at 5 bits
    // and clamped so a level above init never wraps to a huge value.
    function automatic logic [3:0] calc_start_time(
        input logic [3:0] lvl,
        input logic [4:0] init_time,
        input logic [4:0] min_time
    );
        logic [4:0] t;
        if ({1'b0, lvl} >= init_time) t = 5'd0;
        else                          t = init_time - {1'b0, lvl};
        if (t < min_time) t = min_time;
        return t[3:0];
    endfunction

endpackage

// File: rtl/round_timer_controller_start_edge_detect.sv
// Rising-edge detector for the debounced start button. A button that is
// already held when reset releases must be let go before it can start a game.
module start_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic prev;
    logic armed;

    // Track last button level and whether the button has been seen released.
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= btn;
            armed <= armed | ~btn;
        end
    end

    assign pulse = btn & ~prev & armed;

endmodule

// File: rtl/round_timer_controller.sv
// Round timer controller: sequences game rounds, drives the LED bar timer
// (startTime/enable/timeout) and keeps level, lives and rounds-won counters.
module round_timer_controller
    import round_timer_controller_pkg::*;
#(
    parameter int INIT_TIME = DEFAULT_INIT_TIME,
    parameter int MIN_TIME  = DEFAULT_MIN_TIME,
    parameter int MAX_LEVEL = DEFAULT_MAX_LEVEL,
    parameter int LIVES     = DEFAULT_LIVES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startBtn,
    input  logic       hit,
    input  logic       timeout,
    output logic [3:0] startTime,
    output logic       enable,
    output logic [3:0] level,
    output logic [2:0] lives,
    output logic [7:0] roundsWon,
    output logic       gameOver,
    output logic       roundDone
);

    state_t state;
    logic   start;

    start_edge_detect u_start_edge_detect (
        .clk   (clk),
        .rst   (rst),
        .btn   (startBtn),
        .pulse (start)
    );

    // Game FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every output flop gets a reset value so the timer sees a clean reload.
            state     <= S_IDLE;
            enable    <= 1'b0;
            startTime <= 4'(INIT_TIME);
            level     <= 4'd0;
            lives     <= 3'(LIVES);
            roundsWon <= 8'd0;
            gameOver  <= 1'b0;
            roundDone <= 1'b0;
        end else begin
            roundDone <= 1'b0;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state     <= S_LOAD;
                        level     <= 4'd0;
                        lives     <= 3'(LIVES);
                        roundsWon <= 8'd0;
                        gameOver  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    startTime <= calc_start_time(level, 5'(INIT_TIME), 5'(MIN_TIME));
                    state     <= S_ARM;
                end
                S_ARM: begin
                    enable <= 1'b1;
                    state  <= S_RUN;
                end
                S_RUN: begin
                    if (hit) begin
                        enable <= 1'b0;
                        if (lives <= 3'd1) begin
                            lives    <= 3'd0;
                            gameOver <= 1'b1;
                            state    <= S_OVER;
                        end else begin
                            lives <= lives - 3'd1;
                            state <= S_LOAD;
                        end
                    end else if (timeout) begin
                        enable    <= 1'b0;
                        roundDone <= 1'b1;
                        if (level < 4'(MAX_LEVEL)) level <= level + 4'd1;
                        if (roundsWon != 8'hFF)    roundsWon <= roundsWon + 8'd1;
                        state     <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    state <= S_LOAD;
                end
                default: begin
                    enable <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_timer_controller.sv
// Directed bench for round_timer_controller: start sequencing, level/round
// counters, floor and saturation, hit priority, game over, async reset.
module tb_round_timer_controller;
    import round_timer_controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       startBtn;
    logic       hit;
    logic       timeout;
    logic [3:0] startTime;
    logic       enable;
    logic [3:0] level;
    logic [2:0] lives;
    logic [7:0] roundsWon;
    logic       gameOver;
    logic       roundDone;

    int checks   = 0;
    int failures = 0;

    round_timer_controller dut (
        .clk       (clk),
        .rst       (rst),
        .startBtn  (startBtn),
        .hit       (hit),
        .timeout   (timeout),
        .startTime (startTime),
        .enable    (enable),
        .level     (level),
        .lives     (lives),
        .roundsWon (roundsWon),
        .gameOver  (gameOver),
        .roundDone (roundDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From RUN: expire the round, keep timeout stale through LOAD/ARM, return to RUN.
    task automatic round_timeout();
        timeout = 1'b1;
        tick();
        check("adv_round_done", roundDone, 1);
        check("adv_enable", enable, 0);
        tick();
        check("load_round_done_clear", roundDone, 0);
        tick();
        timeout = 1'b0;
        tick();
        check("rerun_enable", enable, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_enable"},    enable,    0);
        check({tag, "_starttime"}, startTime, 9);
        check({tag, "_level"},     level,     0);
        check({tag, "_lives"},     lives,     3);
        check({tag, "_rounds"},    roundsWon, 0);
        check({tag, "_gameover"},  gameOver,  0);
        check({tag, "_rounddone"}, roundDone, 0);
    endtask

    initial begin
        rst = 1'b1; startBtn = 1'b0; hit = 1'b0; timeout = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();

        // Start: LOAD, ARM, then enable rises on the second edge after LOAD.
        startBtn = 1'b1;
        tick();
        check("load_enable", enable, 0);
        check("load_level", level, 0);
        tick();
        check("arm_enable", enable, 0);
        check("arm_starttime", startTime, 9);
        startBtn = 1'b0;
        tick();
        check("run_enable", enable, 1);
        check("run_lives", lives, 3);

        // Three survived rounds.
        repeat (3) round_timeout();
        check("l3_level", level, 3);
        check("l3_starttime", startTime, 6);
        check("l3_rounds", roundsWon, 3);

        // Up to level 8, then floor and saturation.
        repeat (5) round_timeout();
        check("l8_level", level, 8);
        check("l8_starttime", startTime, 3);
        round_timeout();
        check("l9_level", level, 9);
        check("l9_starttime", startTime, 3);
        round_timeout();
        check("sat_level", level, 9);
        check("sat_starttime", startTime, 3);
        check("sat_rounds", roundsWon, 10);

        // Hit and timeout together count only as a hit.
        hit = 1'b1; timeout = 1'b1;
        tick();
        check("both_lives", lives, 2);
        check("both_round_done", roundDone, 0);
        check("both_level", level, 9);
        check("both_enable", enable, 0);
        hit = 1'b0; timeout = 1'b0;
        tick();
        hit = 1'b1;                       // hit during ARM must be ignored
        tick();
        hit = 1'b0;
        check("arm_hit_lives", lives, 2);
        check("both_rerun_enable", enable, 1);

        // Remaining hits with the start button held throughout.
        startBtn = 1'b1;
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("hit2_lives", lives, 1);
        tick();
        tick();
        check("hit2_rerun_enable", enable, 1);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("over_lives", lives, 0);
        check("over_gameover", gameOver, 1);
        check("over_enable", enable, 0);
        repeat (3) tick();
        check("held_gameover", gameOver, 1);
        check("held_level", level, 9);
        check("held_rounds", roundsWon, 10);

        // Release and press again restarts the game.
        startBtn = 1'b0;
        tick();
        startBtn = 1'b1;
        tick();
        check("restart_level", level, 0);
        check("restart_lives", lives, 3);
        check("restart_gameover", gameOver, 0);
        check("restart_rounds", roundsWon, 0);
        startBtn = 1'b0;
        tick();
        tick();
        check("restart_enable", enable, 1);
        round_timeout();
        check("pre_rst_level", level, 1);
        check("pre_rst_starttime", startTime, 8);

        // Asynchronous reset between edges while in RUN, button held.
        #3;
        startBtn = 1'b1;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick();
        check("held_after_rst_enable", enable, 0);
        startBtn = 1'b0;
        tick();
        startBtn = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_enable", enable, 1);
        check("post_rst_starttime", startTime, 9);
        startBtn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
